// File: rtl/leg_drive_pkg.sv
// Shared types and constants for the leg-drive channel arbiter.
// The state enum and direction encodings are used by the arbiter and its bench.
package leg_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DEAD  = 2'd2
  } state_e;

  localparam logic [1:0] DIR_COAST   = 2'b00;
  localparam logic [1:0] DIR_FWD     = 2'b01;
  localparam logic [1:0] DIR_REV     = 2'b10;
  localparam logic [1:0] DIR_ILLEGAL = 2'b11;

  function automatic logic is_illegal(input logic [1:0] cmd);
    return cmd == DIR_ILLEGAL;
  endfunction

  // Anything that is not a real drive direction collapses to coast.
  function automatic logic [1:0] filter_cmd(input logic [1:0] cmd);
    logic [1:0] res;
    res = DIR_COAST;
    case (cmd)
      DIR_FWD: res = DIR_FWD;
      DIR_REV: res = DIR_REV;
      default: res = DIR_COAST;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/leg_drive_arbiter_mux2.sv
// Two-input datapath multiplexer (MUX2) selecting between the requester commands.
// sel=0 passes inPort1, sel=1 passes inPort2.
module MUX2 #(
  parameter int W = 2
) (
  input  logic [W-1:0] inPort1,
  input  logic [W-1:0] inPort2,
  input  logic         sel,
  output logic [W-1:0] outPort
);

  assign outPort = sel ? inPort2 : inPort1;

endmodule

// File: rtl/leg_drive_arbiter.sv
// Round-robin arbiter sharing one 2-bit H-bridge direction channel between two requesters,
// with enforced dead-time between owners. Optional watchdog release: `define ARB_WATCHDOG_EN.
module leg_drive_arbiter
  import leg_drive_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_GRANT  = 1024,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       req1,
  input  logic       req2,
  input  logic [1:0] cmd1,
  input  logic [1:0] cmd2,
  output logic       gnt1,
  output logic       gnt2,
  output logic       sel,
  output logic [1:0] outPort,
  output logic       busy,
  output logic       errIllegal,
  output logic       timeoutPulse,
  output logic [1:0] dbg_state
);

  // Handshake: a requester raises reqN and holds it for the whole ownership; gntN rises one
  // edge after arbitration in IDLE and falls on the edge after reqN is sampled low (or on a
  // watchdog release). Dropping reqN is the only way an owner hands the channel back.

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic             gnt1_q, gnt1_d;
  logic             gnt2_q, gnt2_d;
  logic             sel_q, sel_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [1:0]       out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mux_cmd;
  logic             owner_req;
  logic             wd_fire;
  logic             pick2;

  MUX2 #(.W(2)) u_mux (
    .inPort1 (cmd1),
    .inPort2 (cmd2),
    .sel     (sel_q),
    .outPort (mux_cmd)
  );

  assign owner_req = sel_q ? req2 : req1;

`ifdef ARB_WATCHDOG_EN
  logic other_req;
  logic tout_q, tout_d;

  assign other_req = sel_q ? req1 : req2;
  // In GRANT the counter holds the number of grant cycles so far, saturating at MAX_GRANT.
  assign wd_fire   = (state_q == GRANT) && owner_req && other_req &&
                     (cnt_q >= CNT_W'(MAX_GRANT));
  assign tout_d    = wd_fire;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tout_q <= 1'b0;
    end else begin
      tout_q <= tout_d;
    end
  end

  assign timeoutPulse = tout_q;
`else
  assign wd_fire      = 1'b0;
  assign timeoutPulse = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt1_d  = gnt1_q;
    gnt2_d  = gnt2_q;
    sel_d   = sel_q;
    out_d   = DIR_COAST;
    err_d   = 1'b0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    // last_q=1 means requester 2 owned last, so a tie goes to requester 1.
    pick2   = req2 && (!req1 || !last_q);
    unique case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          state_d = GRANT;
          gnt1_d  = !pick2;
          gnt2_d  = pick2;
          sel_d   = pick2;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        if (!owner_req || wd_fire) begin
          gnt1_d  = 1'b0;
          gnt2_d  = 1'b0;
          last_d  = sel_q;
          cnt_d   = GAP_LOAD;
          state_d = (GAP_CYCLES == 0) ? IDLE : DEAD;
        end else begin
          out_d = filter_cmd(mux_cmd);
          err_d = is_illegal(mux_cmd);
`ifdef ARB_WATCHDOG_EN
          if (cnt_q < CNT_W'(MAX_GRANT)) begin
            cnt_d = cnt_q + CNT_ONE;
          end
`endif
        end
      end
      DEAD: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      sel_q   <= 1'b0;
      out_q   <= DIR_COAST;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt1       = gnt1_q;
  assign gnt2       = gnt2_q;
  assign sel        = sel_q;
  assign outPort    = out_q;
  assign errIllegal = err_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_leg_drive_arbiter.sv
// Bench for leg_drive_arbiter: directed scenarios plus random traffic, every cycle compared
// against an ownership/quiet-time reference model.
`timescale 1ns/1ps
module tb_leg_drive_arbiter;

  localparam int GAP  = 4;
  localparam int MAXG = 16;
  localparam int CW   = 11;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       req1 = 1'b0;
  logic       req2 = 1'b0;
  logic [1:0] cmd1 = 2'b00;
  logic [1:0] cmd2 = 2'b00;
  logic       gnt1, gnt2, sel, busy, errIllegal, timeoutPulse;
  logic [1:0] outPort, dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: who owns the channel, how many quiet cycles remain, who owned last.
  int         m_owner, m_quiet, m_last, m_gcycles;
  logic       m_sel, m_err, m_tout;
  logic [1:0] m_out;
  logic [1:0] prev_out;
  logic       prev_sel;

  leg_drive_arbiter #(
    .GAP_CYCLES (GAP),
    .MAX_GRANT  (MAXG),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .req1         (req1),
    .req2         (req2),
    .cmd1         (cmd1),
    .cmd2         (cmd2),
    .gnt1         (gnt1),
    .gnt2         (gnt2),
    .sel          (sel),
    .outPort      (outPort),
    .busy         (busy),
    .errIllegal   (errIllegal),
    .timeoutPulse (timeoutPulse),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = 0;
    m_quiet   = 0;
    m_last    = 2;
    m_gcycles = 0;
    m_sel     = 1'b0;
    m_err     = 1'b0;
    m_tout    = 1'b0;
    m_out     = 2'b00;
    prev_out  = 2'b00;
    prev_sel  = 1'b0;
  endtask

  task automatic model_step();
    bit         own_req, oth_req;
    logic [1:0] c;
    m_err  = 1'b0;
    m_tout = 1'b0;
    if (m_owner != 0) begin
      own_req = (m_owner == 1) ? req1 : req2;
      oth_req = (m_owner == 1) ? req2 : req1;
      if (!own_req || (WD && oth_req && m_gcycles >= MAXG)) begin
        m_tout  = own_req;
        m_last  = m_owner;
        m_owner = 0;
        m_quiet = GAP;
        m_out   = 2'b00;
      end else begin
        c     = (m_owner == 1) ? cmd1 : cmd2;
        m_err = (c == 2'b11);
        m_out = m_err ? 2'b00 : c;
        if (m_gcycles < MAXG) m_gcycles++;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
      m_out = 2'b00;
    end else begin
      m_out = 2'b00;
      if (req1 && req2) m_owner = (m_last == 1) ? 2 : 1;
      else if (req1)    m_owner = 1;
      else if (req2)    m_owner = 2;
      if (m_owner != 0) begin
        m_sel     = (m_owner == 2);
        m_gcycles = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("gnt1", {7'd0, gnt1}, {7'd0, m_owner == 1});
    chk("gnt2", {7'd0, gnt2}, {7'd0, m_owner == 2});
    chk("sel", {7'd0, sel}, {7'd0, m_sel});
    chk("outPort", {6'd0, outPort}, {6'd0, m_out});
    chk("busy", {7'd0, busy}, {7'd0, (m_owner != 0) || (m_quiet > 0)});
    chk("errIllegal", {7'd0, errIllegal}, {7'd0, m_err});
    chk("timeoutPulse", {7'd0, timeoutPulse}, {7'd0, m_tout});
    chk("gnt_mutex", {7'd0, gnt1 & gnt2}, 8'd0);
    if (prev_out != 2'b00 && outPort != 2'b00)
      chk("direct_handover", {7'd0, prev_sel != sel}, 8'd0);
    prev_out = outPort;
    prev_sel = sel;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int gap_cnt;
    int fire_at;
    int tcount;

    // Reset values
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rstN = 1'b1;

    // First grant latency
    req1 = 1'b1;
    cmd1 = 2'b01;
    cycle();
    chk("lat_gnt1", {7'd0, gnt1}, 8'd1);
    chk("lat_sel", {7'd0, sel}, 8'd0);
    cycle();
    chk("lat_out", {6'd0, outPort}, 8'd1);
    chk("lat_busy", {7'd0, busy}, 8'd1);

    // Illegal command filtered, grant kept
    cmd1 = 2'b11;
    cycle();
    chk("illegal_out", {6'd0, outPort}, 8'd0);
    chk("illegal_err", {7'd0, errIllegal}, 8'd1);
    chk("illegal_gnt1", {7'd0, gnt1}, 8'd1);
    cmd1 = 2'b10;
    cycle();
    chk("after_illegal_out", {6'd0, outPort}, 8'd2);
    chk("after_illegal_err", {7'd0, errIllegal}, 8'd0);

    // Handover with pending requester: fwd owner to rev owner
    cmd1 = 2'b01;
    req2 = 1'b1;
    cmd2 = 2'b10;
    cycle();
    cycle();
    chk("pre_handover_out", {6'd0, outPort}, 8'd1);
    req1 = 1'b0;
    gap_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (gnt2) break;
      if (!gnt1 && !gnt2) gap_cnt++;
    end
    chk("dead_gap", gap_cnt[7:0], 8'(GAP + 1));
    chk("handover_gnt2", {7'd0, gnt2}, 8'd1);
    cycle();
    chk("cmd2_out", {6'd0, outPort}, 8'd2);

    // Ties alternate
    req2 = 1'b0;
    repeat (GAP + 3) cycle();
    req1 = 1'b1;
    req2 = 1'b1;
    cycle();
    chk("tie_a_gnt1", {7'd0, gnt1}, 8'd1);
    req1 = 1'b0;
    repeat (GAP + 3) cycle();
    chk("tie_a_then_gnt2", {7'd0, gnt2}, 8'd1);
    req2 = 1'b0;
    repeat (GAP + 3) cycle();
    req1 = 1'b1;
    req2 = 1'b1;
    cycle();
    chk("tie_b_gnt1", {7'd0, gnt1}, 8'd1);

    // Asynchronous reset mid-grant
    req2 = 1'b0;
    cmd1 = 2'b10;
    cycle();
    cycle();
    chk("pre_rst_out", {6'd0, outPort}, 8'd2);
    #1;
    rstN = 1'b0;
    #1;
    chk("rst_out", {6'd0, outPort}, 8'd0);
    chk("rst_gnt1", {7'd0, gnt1}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    model_reset();
    req1 = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    req1 = 1'b1;
    req2 = 1'b1;
    cmd1 = 2'b01;
    cmd2 = 2'b10;
    cycle();
    chk("post_rst_tie", {7'd0, gnt1}, 8'd1);

    // Long contested grant: watchdog release when enabled
    fire_at = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (timeoutPulse && fire_at == 0) fire_at = i;
    end
`ifdef ARB_WATCHDOG_EN
    chk("wd_grant_cycles", fire_at[7:0], 8'(MAXG));
`else
    chk("no_wd_pulse", fire_at[7:0], 8'd0);
`endif

    // Long uncontested grant: never times out
    req1 = 1'b0;
    req2 = 1'b0;
    repeat (GAP + 3) cycle();
    req1 = 1'b1;
    tcount = 0;
    repeat (40) begin
      cycle();
      if (timeoutPulse) tcount++;
    end
    chk("wd_uncontested", tcount[7:0], 8'd0);
    chk("uncontested_gnt1", {7'd0, gnt1}, 8'd1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if ($urandom_range(0, 7) == 0) req2 = ~req2;
      if ($urandom_range(0, 3) == 0) cmd1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) cmd2 = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
